// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan
// N-channel, WIDTH-bit registered multiplexer with two modes:
//   mode=0 : manual select via sel
//   mode=1 : auto-scan, DWELL enabled cycles per channel, wrap pulse on rollover
// Outputs are registered one cycle after the sampled inputs and carry the
// channel index and a valid strobe for downstream sampling/display logic.
//
// Optional feature macro: MUX_CH_MASK_EN
//   Adds ch_mask (1 = channel enabled). Scan visits only enabled channels,
//   manual select of a masked channel returns y=0 / y_valid=0, and an all-zero
//   mask in scan mode freezes everything with y_valid=0. Without the macro the
//   block behaves as if every channel were enabled.
//
// FSM states (tracked as mode_q):
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_MANUAL  | manual select; scan channel/dwell counters held at zero
//   ST_SCAN    | scanning; cur_ch/dwell_cnt carry the position in the scan

module mux_nx1_scan #(
  parameter int N_CH  = 8,
  parameter int WIDTH = 8,
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  input  logic                  en,
`ifdef MUX_CH_MASK_EN
  input  logic [N_CH-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]      y,
  output logic [SEL_W-1:0]      y_ch,
  output logic                  y_valid,
  output logic                  wrap
);

  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             mode_q;

  logic [SEL_W-1:0] cur_ch;
  logic [DCW-1:0]   dwell_cnt;
  // set by an advance whose next index did not increase; reported as wrap
  // on the first sample of the new channel
  logic             wrap_pend;

  logic [N_CH-1:0]  mask_v;
  logic             any_en;
  logic [SEL_W-1:0] first_en;
  logic             entry;
  logic [SEL_W-1:0] eff_ch;
  logic [DCW-1:0]   eff_dwell;
  logic [WIDTH-1:0] scan_data;
  logic [SEL_W-1:0] next_ch;
  logic             adv;
  logic             adv_wrap;
  logic [WIDTH-1:0] man_data;
  logic             man_ok;

  logic [WIDTH-1:0] y_d;
  logic [SEL_W-1:0] y_ch_d;
  logic             y_valid_d;
  logic             wrap_d;
  logic [SEL_W-1:0] cur_ch_d;
  logic [DCW-1:0]   dwell_d;
  logic             wrap_pend_d;

`ifdef MUX_CH_MASK_EN
  assign mask_v = ch_mask;
`else
  assign mask_v = '1;
`endif

  assign mode_q = (state_q == ST_SCAN);
  assign any_en = |mask_v;

  // Lowest enabled channel: where scan starts and where it wraps to
  always_comb begin
    first_en = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (mask_v[k]) first_en = SEL_W'(k);
    end
  end

  // Effective scan position: the entry cycle restarts from the first channel
  always_comb begin
    entry     = mode && !mode_q;
    eff_ch    = entry ? first_en : cur_ch;
    eff_dwell = entry ? '0 : dwell_cnt;
    adv       = (eff_dwell == DWELL_LAST);
  end

  // Next enabled channel above eff_ch, falling back to the lowest enabled one
  always_comb begin
    logic found_above;
    found_above = 1'b0;
    next_ch     = first_en;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (mask_v[k] && (SEL_W'(k) > eff_ch)) begin
        next_ch     = SEL_W'(k);
        found_above = 1'b1;
      end
    end
    if (!found_above) next_ch = first_en;
    adv_wrap = (next_ch <= eff_ch);
  end

  // Data selection for both modes; manual hit only for in-range, enabled sel
  always_comb begin
    scan_data = '0;
    man_data  = '0;
    man_ok    = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (SEL_W'(k) == eff_ch) scan_data = din[k*WIDTH +: WIDTH];
      if ((SEL_W'(k) == sel) && mask_v[k]) begin
        man_data = din[k*WIDTH +: WIDTH];
        man_ok   = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_MANUAL;
    else     state_q <= state_d;
  end

  // FSM next state: follows mode on enabled cycles; an empty mask blocks scan entry
  always_comb begin
    state_d = state_q;
    if (en) begin
      if (!mode)       state_d = ST_MANUAL;
      else if (any_en) state_d = ST_SCAN;
    end
  end

  // FSM outputs: next datapath and counter values
  always_comb begin
    y_d         = y;
    y_ch_d      = y_ch;
    y_valid_d   = 1'b0;
    wrap_d      = 1'b0;
    cur_ch_d    = cur_ch;
    dwell_d     = dwell_cnt;
    wrap_pend_d = wrap_pend;
    if (en) begin
      if (!mode) begin
        y_d         = man_ok ? man_data : '0;
        y_ch_d      = sel;
        y_valid_d   = man_ok;
        cur_ch_d    = '0;
        dwell_d     = '0;
        wrap_pend_d = 1'b0;
      end else if (any_en) begin
        y_d       = scan_data;
        y_ch_d    = eff_ch;
        y_valid_d = 1'b1;
        wrap_d    = !entry && (eff_dwell == '0) && wrap_pend;
        if (adv) begin
          dwell_d     = '0;
          cur_ch_d    = next_ch;
          wrap_pend_d = adv_wrap;
        end else begin
          dwell_d  = eff_dwell + DCW'(1);
          cur_ch_d = eff_ch;
          if (entry) wrap_pend_d = 1'b0;
        end
      end
    end
  end

  // Output and counter registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y         <= '0;
      y_ch      <= '0;
      y_valid   <= 1'b0;
      wrap      <= 1'b0;
      cur_ch    <= '0;
      dwell_cnt <= '0;
      wrap_pend <= 1'b0;
    end else begin
      y         <= y_d;
      y_ch      <= y_ch_d;
      y_valid   <= y_valid_d;
      wrap      <= wrap_d;
      cur_ch    <= cur_ch_d;
      dwell_cnt <= dwell_d;
      wrap_pend <= wrap_pend_d;
    end
  end

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed bench for mux_nx1_scan: three instances share the control inputs
//   dut  : N_CH=8, DWELL=4
//   dut1 : N_CH=8, DWELL=1
//   dut6 : N_CH=6, DWELL=4 (sel 6/7 out of range)

module tb_mux_nx1_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] din;
  logic [2:0]  sel;
  logic        mode;
  logic        en;
`ifdef MUX_CH_MASK_EN
  logic [7:0]  ch_mask;
`endif

  logic [7:0]  y,  y1,  y6;
  logic [2:0]  yc, yc1, yc6;
  logic        v,  v1,  v6;
  logic        w,  w1,  w6;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mux_nx1_scan #(.N_CH(8), .WIDTH(8), .SEL_W(3), .DWELL(4)) dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .en(en),
`ifdef MUX_CH_MASK_EN
    .ch_mask(ch_mask),
`endif
    .y(y), .y_ch(yc), .y_valid(v), .wrap(w)
  );

  mux_nx1_scan #(.N_CH(8), .WIDTH(8), .SEL_W(3), .DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .en(en),
`ifdef MUX_CH_MASK_EN
    .ch_mask(ch_mask),
`endif
    .y(y1), .y_ch(yc1), .y_valid(v1), .wrap(w1)
  );

  mux_nx1_scan #(.N_CH(6), .WIDTH(8), .SEL_W(3), .DWELL(4)) dut6 (
    .clk(clk), .rst(rst), .din(din[47:0]), .sel(sel), .mode(mode), .en(en),
`ifdef MUX_CH_MASK_EN
    .ch_mask(ch_mask[5:0]),
`endif
    .y(y6), .y_ch(yc6), .y_valid(v6), .wrap(w6)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one rising edge, then sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    sel  = 3'd0;
    mode = 1'b0;
    en   = 1'b0;
`ifdef MUX_CH_MASK_EN
    ch_mask = 8'hFF;
`endif
    for (int k = 0; k < 8; k++) din[k*8 +: 8] = 8'(16 + k);

    // reset state
    tick();
    tick();
    chk("rst y",       32'(y),  32'h0);
    chk("rst y_ch",    32'(yc), 32'h0);
    chk("rst y_valid", 32'(v),  32'h0);
    chk("rst wrap",    32'(w),  32'h0);
    rst = 1'b0;

    // manual select
    en  = 1'b1;
    sel = 3'd5;
    tick();
    chk("man5 y",       32'(y),  32'h15);
    chk("man5 y_ch",    32'(yc), 32'h5);
    chk("man5 y_valid", 32'(v),  32'h1);
    chk("man5 wrap",    32'(w),  32'h0);
    chk("man5 n6 y",    32'(y6), 32'h15);
    sel = 3'd3;
    tick();
    chk("man3 y",       32'(y),  32'h13);
    chk("man3 y_ch",    32'(yc), 32'h3);
    sel = 3'd7;
    tick();
    chk("man7 y",          32'(y),   32'h17);
    chk("man7 y_valid",    32'(v),   32'h1);
    chk("man7 n6 y",       32'(y6),  32'h0);
    chk("man7 n6 y_ch",    32'(yc6), 32'h7);
    chk("man7 n6 y_valid", 32'(v6),  32'h0);
    sel = 3'd6;
    tick();
    chk("man6 y",          32'(y),   32'h16);
    chk("man6 n6 y",       32'(y6),  32'h0);
    chk("man6 n6 y_ch",    32'(yc6), 32'h6);
    chk("man6 n6 y_valid", 32'(v6),  32'h0);

    // en=0 holds data, drops valid
    en  = 1'b0;
    sel = 3'd2;
    tick();
    chk("hold y",       32'(y),  32'h16);
    chk("hold y_ch",    32'(yc), 32'h6);
    chk("hold y_valid", 32'(v),  32'h0);

    // continuous scan from entry
    mode = 1'b1;
    en   = 1'b1;
    for (int i = 1; i <= 42; i++) begin
      int c, c1, c6;
      tick();
      c  = ((i - 1) / 4) % 8;
      c1 = (i - 1) % 8;
      c6 = ((i - 1) / 4) % 6;
      chk($sformatf("scan%0d y_ch", i),    32'(yc), 32'(c));
      chk($sformatf("scan%0d y", i),       32'(y),  32'(16 + c));
      chk($sformatf("scan%0d y_valid", i), 32'(v),  32'h1);
      chk($sformatf("scan%0d wrap", i),    32'(w),  32'(i == 33));
      chk($sformatf("scan%0d d1 y_ch", i), 32'(yc1), 32'(c1));
      chk($sformatf("scan%0d d1 wrap", i), 32'(w1),  32'(i > 1 && c1 == 0));
      chk($sformatf("scan%0d n6 y_ch", i), 32'(yc6), 32'(c6));
      chk($sformatf("scan%0d n6 wrap", i), 32'(w6),  32'(i == 25));
    end

    // pause in the middle of channel 2's dwell
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("gate%0d y_ch", i),    32'(yc), 32'h2);
      chk($sformatf("gate%0d y", i),       32'(y),  32'h12);
      chk($sformatf("gate%0d y_valid", i), 32'(v),  32'h0);
      chk($sformatf("gate%0d wrap", i),    32'(w),  32'h0);
    end
    en = 1'b1;
    tick();
    chk("resume0 y_ch",    32'(yc), 32'h2);
    chk("resume0 y_valid", 32'(v),  32'h1);
    tick();
    chk("resume1 y_ch",    32'(yc), 32'h2);
    tick();
    chk("resume2 y_ch",    32'(yc), 32'h3);
    chk("resume2 y",       32'(y),  32'h13);

    // scan -> manual -> scan restarts at channel 0
    mode = 1'b0;
    sel  = 3'd2;
    tick();
    chk("sw man y_ch", 32'(yc), 32'h2);
    chk("sw man y",    32'(y),  32'h12);
    mode = 1'b1;
    tick();
    chk("reentry y_ch",    32'(yc), 32'h0);
    chk("reentry y",       32'(y),  32'h10);
    chk("reentry wrap",    32'(w),  32'h0);
    chk("reentry d1 y_ch", 32'(yc1), 32'h0);
    tick();
    tick();

    // asynchronous reset mid-scan, checked before the next edge
    rst = 1'b1;
    #2;
    chk("arst y",       32'(y),  32'h0);
    chk("arst y_ch",    32'(yc), 32'h0);
    chk("arst y_valid", 32'(v),  32'h0);
    chk("arst wrap",    32'(w),  32'h0);
    chk("arst d1 y_ch", 32'(yc1), 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("post%0d y_ch", i),    32'(yc), 32'(i == 5));
      chk($sformatf("post%0d y_valid", i), 32'(v),  32'h1);
      chk($sformatf("post%0d wrap", i),    32'(w),  32'h0);
    end

`ifdef MUX_CH_MASK_EN
    ch_mask = 8'b1010_0100;
    mode = 1'b0;
    sel  = 3'd3;
    tick();
    chk("mask man3 y",       32'(y1), 32'h0);
    chk("mask man3 y_valid", 32'(v1), 32'h0);
    sel = 3'd5;
    tick();
    chk("mask man5 y",       32'(y1), 32'h15);
    chk("mask man5 y_valid", 32'(v1), 32'h1);
    mode = 1'b1;
    tick();
    chk("mask s0 y_ch", 32'(yc1), 32'h2);
    chk("mask s0 wrap", 32'(w1),  32'h0);
    tick();
    chk("mask s1 y_ch", 32'(yc1), 32'h5);
    chk("mask s1 wrap", 32'(w1),  32'h0);
    tick();
    chk("mask s2 y_ch", 32'(yc1), 32'h7);
    chk("mask s2 wrap", 32'(w1),  32'h0);
    tick();
    chk("mask s3 y_ch", 32'(yc1), 32'h2);
    chk("mask s3 y",    32'(y1),  32'h12);
    chk("mask s3 wrap", 32'(w1),  32'h1);
    ch_mask = 8'h00;
    tick();
    chk("mask0 y_ch",    32'(yc1), 32'h2);
    chk("mask0 y",       32'(y1),  32'h12);
    chk("mask0 y_valid", 32'(v1),  32'h0);
    chk("mask0 wrap",    32'(w1),  32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_nx1_scan.md
Name: mux_nx1_scan

Overview:
Parametrised N-channel, WIDTH-bit registered multiplexer. Extends the fixed 8x1 combinational mux with two modes: manual select, and an auto-scan mode that steps through every channel at a fixed dwell rate. Feeds downstream sampling/display logic with the data, the channel index and a valid strobe. Used wherever several sources share one registered datapath through time-division sharing.

Parameters:
N_CH, 8, number of input channels; must be 2 or more.
WIDTH, 8, bits per channel.
SEL_W, 3, select/index width; must be at least clog2(N_CH).
DWELL, 4, number of enabled cycles spent on each channel in scan mode; must be 1 or more.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous reset, active-high.
din  in  N_CH*WIDTH  packed channels; channel k is at bits [k*WIDTH +: WIDTH].
sel  in  SEL_W  channel select in manual mode.
mode  in  1  0 = manual, 1 = scan.
en  in  1  clock enable for the datapath and the counters.
y  out  WIDTH  registered selected data.
y_ch  out  SEL_W  registered index of the channel in y.
y_valid  out  1  y/y_ch hold a valid sample from this cycle.
wrap  out  1  one-cycle pulse when the scan wraps from the last channel back to the first.

Behaviour:
- Reset is asynchronous: when rst rises, all state clears immediately with no clock edge.
  - Cleared state: y=0, y_ch=0, y_valid=0, wrap=0, cur_ch=0, dwell_cnt=0, mode_q=0.
- Output latency is 1 cycle from the sampled inputs. No combinational path from inputs to outputs.
- en=0:
  - y and y_ch hold their values.
  - y_valid=0 and wrap=0.
  - cur_ch, dwell_cnt and mode_q are frozen.
- Manual mode (mode=0, en=1):
  - If sel < N_CH: y <= din[sel], y_ch <= sel, y_valid <= 1.
  - If sel >= N_CH: y <= 0, y_ch <= sel, y_valid <= 0.
  - cur_ch and dwell_cnt are cleared; wrap=0.
- Scan mode (mode=1, en=1) is a 2-state FSM, MANUAL and SCAN, tracked by mode_q.
  - Entry cycle (mode=1 and mode_q=0): the effective channel is 0 and the effective dwell count is 0.
  - Each enabled scan cycle: y <= din[eff_ch], y_ch <= eff_ch, y_valid <= 1.
  - If eff_dwell == DWELL-1: dwell_cnt <= 0 and cur_ch <= eff_ch+1, wrapping N_CH-1 to 0. Otherwise dwell_cnt <= eff_dwell+1 and cur_ch holds.
  - wrap=1 for exactly one cycle, in the same cycle y_ch first shows channel 0 after showing channel N_CH-1.
  - The initial entry into scan does not assert wrap.
  - DWELL=1 advances one channel every enabled cycle.
- Mode change takes effect on the next enabled edge.
  - Scan to manual clears the scan state.
  - Re-entering scan always restarts at channel 0.
- Mid-operation reset: the next sample after rst falls follows the rules above from the cleared state. In scan mode that sample is an entry cycle starting at channel 0.

Optional Feature:
MUX_CH_MASK_EN
- When defined:
  - Adds input port ch_mask (N_CH bits); 1 = channel enabled.
  - Scan entry starts at the lowest enabled channel.
  - A scan advance moves to the next enabled channel in circular increasing order.
  - wrap pulses when the new index is less than or equal to the old one. A single enabled channel therefore gives a wrap on every advance.
  - If no channel is enabled: y_valid=0, y and y_ch held, and counters frozen.
  - In manual mode, a masked channel gives y=0 and y_valid=0.
  - A mask change takes effect at the next advance.
- When not defined: no ch_mask port, and behaviour is exactly as above with every channel enabled.

Test Plan:
- Reset: assert rst asynchronously mid-scan -> y=0, y_ch=0, y_valid=0, wrap=0 before the next clk edge; after release with mode=1, en=1 -> first sample is channel 0.
- Manual: N_CH=8, WIDTH=8, din channel k = 8'h10+k, mode=0, en=1, sel=5 -> one edge later y=8'h15, y_ch=5, y_valid=1; sel=3 -> next cycle y=8'h13.
- Out-of-range select: N_CH=6, SEL_W=3, sel=7 -> y=0, y_ch=7, y_valid=0.
- Scan: N_CH=8, DWELL=4, mode=1, en=1 continuously from cycle 0 -> y_ch=0 on outputs cycles 1-4, 1 on 5-8, ..., 7 on 29-32; y_ch=0 on cycle 33 with wrap=1 there only.
- Enable gating: in scan, deassert en for 3 cycles in the middle of channel 2's dwell -> y/y_ch held and y_valid=0; channel 2 completes its remaining dwell after re-enable. Separately, switch to manual and back to scan -> restart at channel 0.
- MUX_CH_MASK_EN: ch_mask=8'b1010_0100, DWELL=1 -> y_ch sequence 2,5,7,2 with wrap on the second 2; ch_mask=0 -> y_valid=0 and outputs held.
